// File: rtl/lu_pkg.sv
// lu_pkg: definitions shared by the 4-bit logic unit, its checker and its benches.
//   - select opcode constants LU_ORAND..LU_GE
//   - checker FSM state encoding
//   - lu_golden(): reference result for one (a, b, sel) vector
package lu_pkg;

   localparam logic [2:0] LU_ORAND = 3'd0;  // |(a & b)
   localparam logic [2:0] LU_OROR  = 3'd1;  // |(a | b)
   localparam logic [2:0] LU_XORR  = 3'd2;  // ^(a ^ b)
   localparam logic [2:0] LU_EQ    = 3'd3;  // a == b
   localparam logic [2:0] LU_LT    = 3'd4;  // a <  b, unsigned
   localparam logic [2:0] LU_GT    = 3'd5;  // a >  b, unsigned
   localparam logic [2:0] LU_LE    = 3'd6;  // a <= b, unsigned
   localparam logic [2:0] LU_GE    = 3'd7;  // a >= b, unsigned

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } lu_state_e;

   // Reference result of the logic unit for one applied vector.
   function automatic logic lu_golden(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [2:0] sel);
      logic r;
      r = 1'b0;
      case (sel)
         LU_ORAND: r = |(a & b);
         LU_OROR:  r = |(a | b);
         LU_XORR:  r = ^(a ^ b);
         LU_EQ:    r = (a == b);
         LU_LT:    r = (a <  b);
         LU_GT:    r = (a >  b);
         LU_LE:    r = (a <= b);
         LU_GE:    r = (a >= b);
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lu_ref_model.sv
// lu_ref_model: combinational golden model of the 4-bit logic unit.
// Ports:
//   a, b     in  4  operands
//   sel      in  3  operation select
//   expected out 1  result the logic unit must produce
module lu_ref_model
   import lu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] sel,
   output logic       expected
);

   assign expected = lu_golden(a, b, sel);

endmodule

// File: rtl/lu_checker.sv
// lu_checker: response monitor for the 4-bit logic unit. Recomputes the expected
// result for every accepted vector, counts vectors and mismatches, captures the
// first failing vector and raises done/pass once num_vec vectors are checked.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, num_vec        begin a run of num_vec vectors (ignored while running)
//   in_valid, in_ready    vector handshake; in_ready only in RUN
//   a, b, sel, out_dut    applied vector and logic-unit result
//   busy, done, pass      run status; pass meaningful while done
//   vec_cnt, err_cnt      vectors checked / mismatches (err_cnt saturates)
//   fail_valid, fail_*    first failing vector
module lu_checker
   import lu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   input  logic [2:0]       sel,
   input  logic             out_dut,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [3:0]       fail_a,
   output logic [3:0]       fail_b,
   output logic [2:0]       fail_sel,
   output logic             fail_out
);

   lu_state_e        state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             fail_valid_q, fail_valid_d;
   logic [3:0]       fail_a_q, fail_a_d;
   logic [3:0]       fail_b_q, fail_b_d;
   logic [2:0]       fail_sel_q, fail_sel_d;
   logic             fail_out_q, fail_out_d;
   logic             expected_s;
   logic             accept_s;

   lu_ref_model u_ref (
      .a        (a),
      .b        (b),
      .sel      (sel),
      .expected (expected_s)
   );

   // in_ready is decoded straight from state so a vector can be taken every cycle.
   assign in_ready = (state_q == ST_RUN);
   assign accept_s = in_valid & in_ready;

   // Next-state, counter and first-fail capture logic.
   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      vec_cnt_d    = vec_cnt_q;
      err_cnt_d    = err_cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      fail_valid_d = fail_valid_q;
      fail_a_d     = fail_a_q;
      fail_b_d     = fail_b_q;
      fail_sel_d   = fail_sel_q;
      fail_out_d   = fail_out_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // New run: previous results are discarded on the start edge.
               num_d        = num_vec;
               vec_cnt_d    = {CNT_W{1'b0}};
               err_cnt_d    = {CNT_W{1'b0}};
               fail_valid_d = 1'b0;
               fail_a_d     = 4'd0;
               fail_b_d     = 4'd0;
               fail_sel_d   = 3'd0;
               fail_out_d   = 1'b0;
               if (num_vec == {CNT_W{1'b0}}) begin
                  // Empty run completes immediately with a clean verdict.
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  pass_d  = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end

         ST_RUN: begin
            if (accept_s) begin
               vec_cnt_d = vec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (out_dut != expected_s) begin
                  if (err_cnt_q != {CNT_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     err_cnt_d = err_cnt_q;
                  end
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     fail_a_d     = a;
                     fail_b_d     = b;
                     fail_sel_d   = sel;
                     fail_out_d   = out_dut;
                  end else begin
                     fail_valid_d = fail_valid_q;
                  end
               end else begin
                  err_cnt_d = err_cnt_q;
               end
               // Last vector: verdict is visible on the same edge, no drain cycle.
               if (vec_cnt_d == num_q) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_d == {CNT_W{1'b0}});
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         num_q        <= {CNT_W{1'b0}};
         vec_cnt_q    <= {CNT_W{1'b0}};
         err_cnt_q    <= {CNT_W{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_valid_q <= 1'b0;
         fail_a_q     <= 4'd0;
         fail_b_q     <= 4'd0;
         fail_sel_q   <= 3'd0;
         fail_out_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         vec_cnt_q    <= vec_cnt_d;
         err_cnt_q    <= err_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_valid_q <= fail_valid_d;
         fail_a_q     <= fail_a_d;
         fail_b_q     <= fail_b_d;
         fail_sel_q   <= fail_sel_d;
         fail_out_q   <= fail_out_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign vec_cnt    = vec_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign fail_valid = fail_valid_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign fail_sel   = fail_sel_q;
   assign fail_out   = fail_out_q;

endmodule

// File: tb/tb_lu_checker.sv
// tb_lu_checker: directed self-checking bench for lu_checker.
module tb_lu_checker;

   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] num_vec;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       a;
   logic [3:0]       b;
   logic [2:0]       sel;
   logic             out_dut;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             fail_valid;
   logic [3:0]       fail_a;
   logic [3:0]       fail_b;
   logic [2:0]       fail_sel;
   logic             fail_out;

   int n_checks;
   int n_errors;

   lu_checker #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_vec    (num_vec),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .sel        (sel),
      .out_dut    (out_dut),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .vec_cnt    (vec_cnt),
      .err_cnt    (err_cnt),
      .fail_valid (fail_valid),
      .fail_a     (fail_a),
      .fail_b     (fail_b),
      .fail_sel   (fail_sel),
      .fail_out   (fail_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent bench model of the logic unit, written with integer arithmetic.
   function automatic logic tb_model(input logic [3:0] ma, input logic [3:0] mb,
                                     input logic [2:0] msel);
      int ia;
      int ib;
      ia = int'(ma);
      ib = int'(mb);
      case (msel)
         3'd0:    return (ma & mb) != 4'd0;
         3'd1:    return (ia + ib) != 0;
         3'd2:    return ($countones(ma) + $countones(mb)) % 2 == 1;
         3'd3:    return ia == ib;
         3'd4:    return ia < ib;
         3'd5:    return ia > ib;
         3'd6:    return !(ia > ib);
         default: return !(ia < ib);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_regs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_vec_cnt"}, 32'(vec_cnt), 32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      chk({tag, "_fail_valid"}, 32'(fail_valid), 32'd0);
      chk({tag, "_fail_vec"}, {21'd0, fail_a, fail_b, fail_sel}, 32'd0);
      chk({tag, "_fail_out"}, 32'(fail_out), 32'd0);
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start   = 1'b1;
      num_vec = n;
      tick();
      start   = 1'b0;
   endtask

   task automatic put_vec(input logic [3:0] va, input logic [3:0] vb,
                          input logic [2:0] vs, input logic vo);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      sel      = vs;
      out_dut  = vo;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [10:0] idx;
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      start    = 1'b0;
      num_vec  = '0;
      in_valid = 1'b0;
      a        = 4'd0;
      b        = 4'd0;
      sel      = 3'd0;
      out_dut  = 1'b0;

      // Reset values
      tick();
      chk_idle_regs("reset");
      rst = 1'b0;
      tick();

      // Reset in the middle of a run after 3 vectors
      do_start(16'd5);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      put_vec(4'd1, 4'd2, 3'd4, 1'b0);  // wrong, gets captured
      put_vec(4'd3, 4'd3, 3'd3, 1'b1);
      put_vec(4'd5, 4'd6, 3'd1, 1'b1);
      chk("mid_vec_cnt", 32'(vec_cnt), 32'd3);
      chk("mid_err_cnt", 32'(err_cnt), 32'd1);
      rst = 1'b1;
      #1;
      chk_idle_regs("async_rst");
      tick();
      rst = 1'b0;
      in_valid = 1'b1;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd0);
      chk("post_rst_vec_cnt", 32'(vec_cnt), 32'd0);
      in_valid = 1'b0;

      // Two correct vectors
      do_start(16'd2);
      put_vec(4'd8, 4'd8, 3'd3, 1'b1);
      chk("two_vec_cnt1", 32'(vec_cnt), 32'd1);
      chk("two_done_early", 32'(done), 32'd0);
      put_vec(4'd1, 4'd2, 3'd3, 1'b0);
      chk("two_done", 32'(done), 32'd1);
      chk("two_busy", 32'(busy), 32'd0);
      chk("two_in_ready", 32'(in_ready), 32'd0);
      chk("two_pass", 32'(pass), 32'd1);
      chk("two_vec_cnt", 32'(vec_cnt), 32'd2);
      chk("two_err_cnt", 32'(err_cnt), 32'd0);
      chk("two_fail_valid", 32'(fail_valid), 32'd0);

      // Three vectors, second and third wrong; first failure is captured
      do_start(16'd3);
      put_vec(4'd3, 4'd5, 3'd2, 1'b0);
      put_vec(4'd1, 4'd2, 3'd4, 1'b0);
      chk("three_fail_valid_mid", 32'(fail_valid), 32'd1);
      put_vec(4'd0, 4'd2, 3'd0, 1'b1);
      chk("three_done", 32'(done), 32'd1);
      chk("three_err_cnt", 32'(err_cnt), 32'd2);
      chk("three_pass", 32'(pass), 32'd0);
      chk("three_fail_a", 32'(fail_a), 32'd1);
      chk("three_fail_b", 32'(fail_b), 32'd2);
      chk("three_fail_sel", 32'(fail_sel), 32'd4);
      chk("three_fail_out", 32'(fail_out), 32'd0);

      // Empty run: done and pass right away, old results cleared
      do_start(16'd0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_pass", 32'(pass), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_in_ready", 32'(in_ready), 32'd0);
      chk("zero_err_cnt", 32'(err_cnt), 32'd0);
      chk("zero_fail_valid", 32'(fail_valid), 32'd0);
      in_valid = 1'b1;
      tick();
      tick();
      chk("zero_in_ready_later", 32'(in_ready), 32'd0);
      chk("zero_vec_cnt", 32'(vec_cnt), 32'd0);
      in_valid = 1'b0;

      // 16 back-to-back vectors, start during RUN ignored, 17th not taken
      do_start(16'd16);
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         a        = 4'(i);
         b        = 4'(15 - i);
         sel      = 3'(i);
         out_dut  = tb_model(a, b, sel);
         start    = (i == 5);
         num_vec  = (i == 5) ? 16'd3 : 16'd16;
         tick();
         start    = 1'b0;
         if (i == 14) begin
            chk("b2b_vec_cnt15", 32'(vec_cnt), 32'd15);
            chk("b2b_done15", 32'(done), 32'd0);
            chk("b2b_busy15", 32'(busy), 32'd1);
         end
      end
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_vec_cnt", 32'(vec_cnt), 32'd16);
      chk("b2b_pass", 32'(pass), 32'd1);
      chk("b2b_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("b2b_no_17th", 32'(vec_cnt), 32'd16);
      in_valid = 1'b0;

      // Full sweep with correct results
      do_start(16'd2048);
      idx = 11'd0;
      for (int i = 0; i < 2048; i++) begin
         idx      = 11'(i);
         in_valid = 1'b1;
         a        = idx[3:0];
         b        = idx[7:4];
         sel      = idx[10:8];
         out_dut  = tb_model(a, b, sel);
         tick();
      end
      in_valid = 1'b0;
      chk("sweep_done", 32'(done), 32'd1);
      chk("sweep_pass", 32'(pass), 32'd1);
      chk("sweep_vec_cnt", 32'(vec_cnt), 32'd2048);
      chk("sweep_err_cnt", 32'(err_cnt), 32'd0);

      // Sweep again, result of vector 1234 (a=2,b=13,sel=4 -> 1) flipped
      do_start(16'd2048);
      for (int i = 0; i < 2048; i++) begin
         idx      = 11'(i);
         in_valid = 1'b1;
         a        = idx[3:0];
         b        = idx[7:4];
         sel      = idx[10:8];
         out_dut  = tb_model(a, b, sel) ^ (i == 1234);
         tick();
      end
      in_valid = 1'b0;
      chk("flip_done", 32'(done), 32'd1);
      chk("flip_pass", 32'(pass), 32'd0);
      chk("flip_err_cnt", 32'(err_cnt), 32'd1);
      chk("flip_fail_valid", 32'(fail_valid), 32'd1);
      chk("flip_fail_a", 32'(fail_a), 32'd2);
      chk("flip_fail_b", 32'(fail_b), 32'd13);
      chk("flip_fail_sel", 32'(fail_sel), 32'd4);
      chk("flip_fail_out", 32'(fail_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lu_checker.md
# lu_checker

Self-checking response monitor for the 4-bit logic unit. It accepts a stream of applied operand/select vectors together with the 1-bit result the logic unit produced, and recomputes the expected result with a golden model. It counts checked vectors and mismatches and captures the first failing vector. It sits downstream of the logic unit in the on-chip self-test path and reports a pass/fail verdict once a programmed number of vectors has been checked.

## Interface
Parameters:
- CNT_W, 16, width of vector/error counters and of num_vec

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse: clear results, begin a run of num_vec vectors
- num_vec  input  CNT_W  vectors to check; sampled on accepted start
- in_valid  input  1  vector present on a/b/sel/out_dut
- in_ready  output  1  checker accepting vectors
- a  input  4  applied operand A
- b  input  4  applied operand B
- sel  input  3  applied select
- out_dut  input  1  logic-unit result for this vector
- busy  output  1  run in progress
- done  output  1  run complete (level, held until next start)
- pass  output  1  valid when done: 1 iff err_cnt==0
- vec_cnt  output  CNT_W  vectors checked this run
- err_cnt  output  CNT_W  mismatches this run, saturating at all-ones
- fail_valid  output  1  a first failure has been captured
- fail_a / fail_b  output  4 each  operands of first failing vector
- fail_sel  output  3  select of first failing vector
- fail_out  output  1  logic-unit result of first failing vector

## Operation
- Golden model, sel: 0 |(a&b); 1 |(a|b); 2 ^(a^b); 3 a==b; 4 a<b; 5 a>b; 6 a<=b; 7 a>=b (unsigned).
- FSM states IDLE, RUN, DONE.
- IDLE: in_ready=0. start -> clear counters/capture, latch num_vec; go to RUN, or to DONE if num_vec==0 (pass=1).
- RUN: in_ready=1. Accept when in_valid&&in_ready. Per accept: vec_cnt+1; if out_dut != expected, err_cnt+1 (saturating); if fail_valid==0, capture a/b/sel/out_dut and set fail_valid. Accept making vec_cnt==num_vec -> DONE.
- RUN: start is ignored.
- DONE: in_ready=0, done=1, pass=(err_cnt==0). start behaves as in IDLE (new run). Vectors offered in DONE/IDLE are not consumed.
- Counter wrap impossible: vec_cnt bounded by num_vec; err_cnt saturates.

## Timing
- All outputs registered except in_ready (decoded from state).
- Reset values: state IDLE, in_ready 0, busy 0, done 0, pass 0, vec_cnt 0, err_cnt 0, fail_valid 0, fail_a/fail_b/fail_sel/fail_out 0.
- Accept at edge k: counters/capture visible after edge k (1-cycle latency).
- Last accept at edge k: done=1, busy=0, in_ready=0 after edge k. No extra drain cycle.
- Back-to-back: one vector per cycle while in_valid held high.
- start at edge k: busy=1 (or done=1 if num_vec==0) after edge k; old results cleared on the same edge.
- rst asserted mid-run: immediate return to reset values; the run is discarded.

## Structure
- Shared package lu_pkg: sel opcode localparams (LU_ORAND..LU_GE), state enum, function/constants for golden model, shared with the logic unit and its benches.
- One sub-module: lu_ref_model (combinational a,b,sel -> expected), reusable by other self-test blocks.
- Top: FSM, counters, first-fail capture register.

## Test plan
- Reset mid-run after 3 vectors -> all outputs at reset values; in_ready=0 next cycle.
- num_vec=2; vectors (a=8,b=8,sel=3,out=1), (a=1,b=2,sel=3,out=0) -> done=1, pass=1, vec_cnt=2, err_cnt=0, fail_valid=0.
- num_vec=3; second vector (a=1,b=2,sel=4,out=0) wrong, third (a=0,b=2,sel=0,out=1) wrong -> err_cnt=2, pass=0; fail_a=1, fail_b=2, fail_sel=4, fail_out=0.
- num_vec=0 start -> done=1, pass=1 next cycle; in_ready never asserts.
- 16 back-to-back vectors, in_valid held high, num_vec=16 -> done one cycle after 16th accept; 17th offered vector not accepted; start during RUN ignored.
- Sweep all 2048 a/b/sel combos with a correct model driving out_dut, num_vec=2048 -> pass=1; repeat with one flipped result -> err_cnt=1 and capture matches it.
